// File: rtl/ecc_enc_pipe.sv
// Two-stage pipelined extended-Hamming (SECDED) encoder with per-word mode and
// valid/ready flow control; stage 1 holds the masked info word, stage 2 the codeword.
module ecc_enc_pipe #(
    parameter int  MODE_CNT           = 3,
    localparam int MAX_CODEWORD_WIDTH = 2 ** (MODE_CNT + 2),
    localparam int MAX_INFO_WIDTH     = MAX_CODEWORD_WIDTH - (MODE_CNT + 3)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     in_data,
    input  logic [1:0]                    in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
    output logic [1:0]                    out_mode,
    output logic                          out_err
);

    localparam int CW = MAX_CODEWORD_WIDTH;
    localparam int IW = MAX_INFO_WIDTH;
    localparam logic [2:0]    MODE_LIM = 3'(MODE_CNT);
    localparam logic [IW-1:0] ALL_ONES = '1;

    // Hamming position of info bit i: count upward from i+1, skipping powers of two.
    function automatic int data_pos(input int i);
        int p;
        p = i + 1;
        for (int t = 0; t < 8; t++) begin
            if ((1 << t) <= p) p = p + 1;
        end
        return p;
    endfunction

    logic            s1_v;
    logic            s1_err;
    logic [1:0]      s1_mode;
    logic [IW-1:0]   s1_info;

    logic            s1_load;
    logic            s2_load;
    logic            in_err;
    logic [IW-1:0]   info_masked;
    logic [CW-1:0]   cw_sel;

    logic [MODE_CNT*IW-1:0] mask_flat;
    logic [MODE_CNT*CW-1:0] cw_flat;

    for (genvar m = 0; m < MODE_CNT; m++) begin : gen_mode
        localparam int R = m + 3;
        localparam int N = 2 ** R;
        localparam int K = N - R - 1;

        logic [CW-1:0] cw;

        assign mask_flat[m*IW +: IW] = ALL_ONES >> (IW - K);

        always_comb begin
            logic [K-1:0] d;
            logic [R-1:0] par_lo;
            d      = s1_info[K-1:0];
            par_lo = '0;
            for (int i = 0; i < K; i++) begin
                par_lo = par_lo ^ (R'(data_pos(i)) & {R{d[i]}});
            end
            cw          = '0;
            cw[N-1:R+1] = d;
            cw[R]       = (^d) ^ (^par_lo);
            cw[R-1:0]   = par_lo;
        end

        assign cw_flat[m*CW +: CW] = cw;
    end

    assign in_err = {1'b0, in_mode} >= MODE_LIM;

    // An invalid mode matches no table entry, so its info and codeword stay zero.
    always_comb begin
        info_masked = '0;
        for (int m = 0; m < MODE_CNT; m++) begin
            if (in_mode == 2'(m)) info_masked = in_data & mask_flat[m*IW +: IW];
        end
    end

    always_comb begin
        cw_sel = '0;
        for (int m = 0; m < MODE_CNT; m++) begin
            if (!s1_err && s1_mode == 2'(m)) cw_sel = cw_flat[m*CW +: CW];
        end
    end

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_v || s2_load;
    assign in_ready = !rst && s1_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_err    <= 1'b0;
            s1_mode   <= '0;
            s1_info   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_v    <= in_valid;
                s1_err  <= in_err;
                s1_mode <= in_mode;
                s1_info <= info_masked;
            end
            if (s2_load) begin
                out_valid <= s1_v;
                out_data  <= cw_sel;
                out_mode  <= s1_mode;
                out_err   <= s1_err;
            end
        end
    end

endmodule

// File: tb/tb_ecc_enc_pipe.sv
// Bench for ecc_enc_pipe: fixed vector table, random traffic with random
// backpressure, stall-capacity and reset-flush sequences, checked through a scoreboard.
module tb_ecc_enc_pipe;

    localparam int MODE_CNT = 3;
    localparam int CW = 32;
    localparam int IW = 26;

    typedef struct packed {
        logic [CW-1:0] data;
        logic [1:0]    mode;
        logic          err;
    } exp_t;

    typedef struct {
        logic [1:0]    mode;
        logic [IW-1:0] data;
        logic [CW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_data;
    logic [1:0]    out_mode;
    logic          out_err;

    exp_t sb[$];
    exp_t drv;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ecc_enc_pipe #(.MODE_CNT(MODE_CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_err   (out_err)
    );

    // Reference: lay the word out in Hamming position order, then compute parity.
    function automatic exp_t model(input logic [1:0] mode, input logic [IW-1:0] data);
        exp_t        e;
        logic [63:0] code;
        logic [63:0] word;
        logic [7:0]  par;
        int          r, n, k, idx;
        e.mode = mode;
        e.err  = 1'b0;
        e.data = '0;
        if (int'(mode) >= MODE_CNT) begin
            e.err = 1'b1;
            return e;
        end
        r = int'(mode) + 3;
        n = 1 << r;
        k = n - r - 1;
        code = '0;
        idx = 0;
        for (int pos = 1; pos < n; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                code[pos] = data[idx];
                idx++;
            end
        end
        par = '0;
        for (int j = 0; j < r; j++) begin
            for (int pos = 1; pos < n; pos++) begin
                if (((pos >> j) & 1) == 1) par[j] = par[j] ^ code[pos];
            end
        end
        par[r] = (^code) ^ (^par);
        word = 64'(data) & ((64'd1 << k) - 64'd1);
        word = (word << (r + 1)) | 64'(par);
        e.data = word[CW-1:0];
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'({out_data, out_mode, out_err}), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_word", 64'({out_data, out_mode, out_err}), 64'(e));
                end
            end
            if (in_valid && in_ready) sb.push_back(drv);
        end
    end

    task automatic send(input logic [1:0] m, input logic [IW-1:0] d, input exp_t e);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        drv      = e;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && sb.size() > 0; c++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    vec_t      tab[9];
    logic [1:0]    bp_mode[4];
    logic [IW-1:0] bp_data[4];
    exp_t      e;
    int        idx;
    logic [CW-1:0] snap;

    initial begin
        tab[0] = '{2'd1, 26'h0000001, 32'h0000_0033, 1'b0};
        tab[1] = '{2'd2, 26'h3FF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tab[2] = '{2'd0, 26'h3FF_FFF0, 32'h0000_0000, 1'b0};
        tab[3] = '{2'd3, 26'h0000123, 32'h0000_0000, 1'b1};
        tab[4] = '{2'd0, 26'h000000B, 32'h0000_00B1, 1'b0};
        tab[5] = '{2'd1, 26'h00007FF, 32'h0000_FFFF, 1'b0};
        tab[6] = '{2'd2, 26'h0000000, 32'h0000_0000, 1'b0};
        tab[7] = '{2'd3, 26'h3FF_FFFF, 32'h0000_0000, 1'b1};
        tab[8] = '{2'd0, 26'h0000001, 32'h0000_001B, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_mode = '0;
        in_data = '0;
        out_ready = 1'b1;
        drv = '0;

        @(negedge clk);
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_in_ready_high", 64'(in_ready), 64'd1);
        tick();

        // Latency: accepted at edge t, valid after edge t+1.
        send(2'd0, 26'hB, '{32'h0000_00B1, 2'd0, 1'b0});
        @(negedge clk);
        check("lat_not_yet_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_data", 64'(out_data), 64'h0000_00B1);
        tick();

        // Table vectors back-to-back at full rate.
        for (int i = 0; i < 9; i++) begin
            send(tab[i].mode, tab[i].data, '{tab[i].exp_data, tab[i].mode, tab[i].exp_err});
        end
        drain();

        // Random traffic under random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [1:0]    m;
                    logic [IW-1:0] d;
                    m = 2'($urandom_range(0, 3));
                    d = IW'($urandom);
                    send(m, d, model(m, d));
                end
            end
            begin
                for (int c = 0; c < 150; c++) begin
                    tick();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Stall capacity: four words offered with the sink stalled.
        bp_mode[0] = 2'd0; bp_data[0] = 26'h5;
        bp_mode[1] = 2'd1; bp_data[1] = 26'h2A5;
        bp_mode[2] = 2'd2; bp_data[2] = 26'h1234567;
        bp_mode[3] = 2'd0; bp_data[3] = 26'hE;
        out_ready = 1'b0;
        idx = 0;
        snap = '0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_mode = bp_mode[idx];
            in_data = bp_data[idx];
            drv = model(bp_mode[idx], bp_data[idx]);
            @(negedge clk);
            if (in_ready) idx++;
            if (c == 3) snap = out_data;
            tick();
        end
        @(negedge clk);
        e = model(bp_mode[0], bp_data[0]);
        check("stall_accepted", 64'(idx), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_stable", 64'(out_data), 64'(snap));
        check("stall_head_word", 64'(out_data), 64'(e.data));
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 4; c++) begin
            in_valid = 1'b1;
            in_mode = bp_mode[idx];
            in_data = bp_data[idx];
            drv = model(bp_mode[idx], bp_data[idx]);
            @(negedge clk);
            if (c == 0) check("release_in_ready", 64'(in_ready), 64'd1);
            if (in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        check("release_all_sent", 64'(idx), 64'd4);
        drain();

        // Reset with two words in flight: neither may ever appear.
        out_ready = 1'b0;
        send(2'd1, 26'h123, model(2'd1, 26'h123));
        send(2'd2, 26'h0ABCDEF, model(2'd2, 26'h0ABCDEF));
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_data", 64'(out_data), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        send(2'd0, 26'h6, model(2'd0, 26'h6));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
